// File: rtl/bin_a_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// Ports: clk, rst_n, start, bin[WIDTH] in; busy, done, bcd[4*DIGITS] out.
module bin_a_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int TW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAXV = (64'd1 << WIDTH) - 64'd1;

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("bin_a_bcd_seq: WIDTH out of range");
  end
  if (pow10(DIGITS) <= MAXV) begin : g_bad_digits
    $error("bin_a_bcd_seq: DIGITS too small");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t                r_state;
  logic [TW-1:0]         r_work;
  logic [CW-1:0]         r_cnt;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_done;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [TW-1:0]         w_adj;
  logic [TW-1:0]         w_work_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [4*DIGITS-1:0]   w_bcd_nxt;
  logic                  w_done_nxt;
  logic                  w_busy_nxt;

  // Nibbles are adjusted independently; no carry crosses a digit.
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_adj[WIDTH+4*d +: 4] >= 4'd5)
        w_adj[WIDTH+4*d +: 4] = w_adj[WIDTH+4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_bcd_nxt   = r_bcd;
    w_done_nxt  = (r_state == FIN);
    // Busy trails the state by one cycle.
    w_busy_nxt  = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_work_nxt  = {{(4*DIGITS){1'b0}}, bin};
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_work_nxt = {w_adj[TW-2:0], 1'b0};
        w_cnt_nxt  = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE)
          w_state_nxt = FIN;
      end
      FIN: begin
        w_bcd_nxt   = r_work[TW-1:WIDTH];
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcd   <= w_bcd_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin_a_bcd_seq.sv
// Testbench for bin_a_bcd_seq (WIDTH=8, DIGITS=3).
// Directed vector table plus hand-written handshake/reset sequences.
module tb_bin_a_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int checks;
  int failures;
  logic [11:0] model_bcd;

  bin_a_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  v;
    logic [11:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called at a negedge while idle. Drives one start and checks
  // the full busy/done/bcd timeline through edge 10.
  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp,
                          input bit noise, input string nm);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy0"}, 32'(busy), 32'(0));
    for (int k = 1; k <= 10; k++) begin
      if (noise) begin
        start = (k < 8) && k[0];
        bin   = 8'd200;
      end
      @(negedge clk);
      if (k < 9) begin
        chk({nm, "_busy"}, 32'(busy), 32'(1));
        chk({nm, "_done_early"}, 32'(done), 32'(0));
        chk({nm, "_bcd_hold"}, 32'(bcd), 32'(model_bcd));
      end else if (k == 9) begin
        chk({nm, "_busy9"}, 32'(busy), 32'(1));
        chk({nm, "_done9"}, 32'(done), 32'(1));
        chk({nm, "_bcd"}, 32'(bcd), 32'(exp));
      end else begin
        chk({nm, "_busy10"}, 32'(busy), 32'(0));
        chk({nm, "_done10"}, 32'(done), 32'(0));
        chk({nm, "_bcd10"}, 32'(bcd), 32'(exp));
      end
    end
    start = 1'b0;
    model_bcd = exp;
  endtask

  vec_t vt[11];

  initial begin
    checks    = 0;
    failures  = 0;
    model_bcd = 12'h000;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = 8'd0;

    vt[0]  = '{8'd0,   12'h000};
    vt[1]  = '{8'd255, 12'h255};
    vt[2]  = '{8'd9,   12'h009};
    vt[3]  = '{8'd100, 12'h100};
    vt[4]  = '{8'd59,  12'h059};
    vt[5]  = '{8'd1,   12'h001};
    vt[6]  = '{8'd10,  12'h010};
    vt[7]  = '{8'd99,  12'h099};
    vt[8]  = '{8'd128, 12'h128};
    vt[9]  = '{8'd254, 12'h254};
    vt[10] = '{8'd5,   12'h005};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_bcd", 32'(bcd), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_conv(vt[i].v, vt[i].exp, 1'b0, $sformatf("vec%0d", i));

    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), to_bcd(v), 1'b0, $sformatf("sweep%0d", v));
      chk("sweep_nib2", 32'(bcd[11:8] <= 4'd9), 32'(1));
      chk("sweep_nib1", 32'(bcd[7:4] <= 4'd9), 32'(1));
      chk("sweep_nib0", 32'(bcd[3:0] <= 4'd9), 32'(1));
    end

    run_conv(8'd42, 12'h042, 1'b1, "ignore");

    start = 1'b1;
    bin   = 8'd173;
    @(negedge clk);
    start = 1'b0;
    bin   = 8'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    model_bcd = 12'h000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abort_hold_done", 32'(done), 32'(0));
      chk("abort_hold_busy", 32'(busy), 32'(0));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'(0));
      chk("post_rst_bcd", 32'(bcd), 32'(0));
    end
    run_conv(8'd7, 12'h007, 1'b0, "after_rst");

    start = 1'b1;
    bin   = 8'd128;
    @(negedge clk);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      chk("held_done", 32'(done), 32'((c % 10) == 9));
      chk("held_busy", 32'(busy), 32'((c % 10) != 0));
      chk("held_bcd", 32'(bcd), 32'((c < 9) ? model_bcd : 12'h128));
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_drain_busy", 32'(busy), 32'(0));
    chk("held_drain_bcd", 32'(bcd), 32'(12'h128));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
